dm_access_arbiter: RTL and testbench
====================================

// Module: dm_access_arbiter
// PURPOSE
// - Shares the single byte-addressed, big-endian data memory port between two requesters: CPU load/store (port C) and program/debug loader (port L).
// - Registers one access at a time, drives the memory for exactly one cycle, then returns a registered response.
// - Sits between the core's MEM stage / loader and the data memory; it is the only driver of the memory's DMWr.
// PARAMETERS
// - ADDR_W    32  address width (byte address)
// - DATA_W    32  data width
// - PRIO_MODE 0   0 = round-robin between C and L; 1 = fixed priority, C always wins
// PORTS
// - clk        in   1       single clock, rising edge
// - rst        in   1       synchronous, active-high reset
// - CReq       in   1       C request valid; held until CGnt
// - CAddr      in   ADDR_W  C byte address
// - CWrData    in   DATA_W  C store data
// - CWr        in   1       C 1 = store, 0 = load
// - CCtrl      in   3       C size/sign: 000 sb/lb, 001 sh/lh, 010 sw/lw, 100 lbu, 101 lhu
// - CGnt       out  1       C request accepted this cycle
// - CDone      out  1       C one-cycle completion pulse
// - CRdData    out  DATA_W  C load data, valid with CDone
// - CErr       out  1       C misalignment error, valid with CDone
// - LReq/LAddr/LWrData/LWr/LCtrl/LGnt/LDone/LRdData/LErr: same as C, loader side
// - DMAddresss out  ADDR_W  memory byte address
// - DMDataWr   out  DATA_W  memory write data
// - DMWr       out  1       memory write enable
// - DMCtrl     out  3       memory size/sign code
// - DMDataRd   in   DATA_W  memory read data (combinational)
// BEHAVIOUR
// - Reset: FSM=IDLE, rr pointer favours C, all outputs 0 (DMWr=0, Gnt/Done/Err=0, RdData=0, DM*=0).
// - FSM: IDLE -> ACCESS -> RESP -> IDLE; one access per 3 cycles; Req only sampled in IDLE.
// - IDLE: if any Req, grant one (Gnt pulse 1 cycle), latch its Addr/WrData/Wr/Ctrl and id; next ACCESS.
// - ACCESS: drive DM* from latch; DMWr=latched Wr only here; capture DMDataRd into resp register; next RESP.
// - RESP: Done=1 for granted id only, RdData=captured data (0 for stores), Err per check; next IDLE.
// - Latency: Gnt at cycle N, DMWr/DM* valid N+1, Done/RdData N+2.
// - Outside ACCESS: DMWr=0, DMAddresss/DMDataWr/DMCtrl hold last value (no glitch into memory).
// - Arbitration: both Req in IDLE -> PRIO_MODE=1: C; PRIO_MODE=0: requester not granted last; pointer updates on each grant.
// - Single Req always granted regardless of pointer.
// - Invalid Ctrl (011,110,111) or store with Ctrl 100/101: DMWr forced 0, completes with RdData=0, Err=0.
// - Req dropped before Gnt: not an error, nothing latched.
// - Reset mid-ACCESS/RESP: next edge IDLE, DMWr=0, no Done issued for the aborted access.
// CONFIGURATION
// - Macro DM_ALIGN_CHECK_EN defined: half with Addr[0]=1 or word with Addr[1:0]!=0 is granted but
//   not forwarded (DMWr=0 in ACCESS), completes with Err=1, RdData=0.
// - Not defined: no check, every valid access forwarded, CErr/LErr tied 0.
// STRUCTURE
// - Package dm_pkg: typedef enum [2:0] dm_ctrl_e {DM_B=000,DM_H=001,DM_W=010,DM_BU=100,DM_HU=101};
//   typedef enum arb_state_e {IDLE,ACCESS,RESP}; requester id typedef (REQ_C, REQ_L).
// - Sub-module dm_rr_picker: 2-way round-robin/fixed picker (req[1:0], prio_mode, ptr -> grant one-hot).
// - Top holds FSM, request latch, response register, alignment check.
// TESTING
// - Reset then idle: all outputs 0 for 5 cycles, DMWr never 1.
// - C sw Addr=0x8 Data=0xDEADBEEF, then lw Addr=0x8 -> DMWr=1 only at N+1, CDone at N+2, CRdData=0xDEADBEEF.
// - C and L Req same cycle, PRIO_MODE=0 -> C first, L next; repeat both -> L first; PRIO_MODE=1 -> C both times.
// - L sb Addr=0x3 Data=0x80, C lb Addr=0x0 (DM[3]=0x80) -> data matches memory sign-extension; lbu -> 0x00000080.
// - DM_ALIGN_CHECK_EN: C lw Addr=0x6 -> DMWr=0, CDone+CErr=1, CRdData=0; without macro -> forwarded, CErr=0.
// - rst asserted in ACCESS of a store -> next cycle IDLE, DMWr=0, no CDone; following request served normally.

Source files
------------

// File: rtl/dm_pkg.sv
// ---------------------------------------------------------------------------
// dm_pkg: shared types and access-code helpers for the data-memory arbiter.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package dm_pkg;

  typedef enum logic [2:0] {
    DM_B  = 3'b000,
    DM_H  = 3'b001,
    DM_W  = 3'b010,
    DM_BU = 3'b100,
    DM_HU = 3'b101
  } dm_ctrl_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  typedef enum logic {
    REQ_C = 1'b0,
    REQ_L = 1'b1
  } req_id_e;

  // Unsigned sizes only exist for loads; a store cannot zero-extend.
  function automatic logic ctrl_valid(input logic [2:0] ctrl, input logic wr);
    logic v;
    v = 1'b0;
    case (ctrl)
      DM_B, DM_H, DM_W: v = 1'b1;
      DM_BU, DM_HU:     v = !wr;
      default:          v = 1'b0;
    endcase
    return v;
  endfunction

  function automatic logic ctrl_misaligned(input logic [2:0] ctrl, input logic [1:0] addr_lo);
    logic m;
    m = 1'b0;
    case (ctrl)
      DM_H, DM_HU: m = addr_lo[0];
      DM_W:        m = (addr_lo != 2'b00);
      default:     m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dm_rr_picker.sv
// ---------------------------------------------------------------------------
// dm_rr_picker: two-way picker, round-robin or fixed (port 0 wins). Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dm_rr_picker (
  input  logic [1:0] i_req,
  input  logic       i_prio_mode,
  input  logic       i_ptr,
  output logic [1:0] o_gnt
);

  // i_ptr names the favoured requester on contention (0 = port 0).
  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = (i_prio_mode || !i_ptr) ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/dm_access_arbiter.sv
// ---------------------------------------------------------------------------
// dm_access_arbiter: shares one data-memory port between CPU (C) and loader (L).
// Optional macro DM_ALIGN_CHECK_EN: misaligned half/word accesses end with Err.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dm_access_arbiter
  import dm_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int PRIO_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              CReq,
  input  logic [ADDR_W-1:0] CAddr,
  input  logic [DATA_W-1:0] CWrData,
  input  logic              CWr,
  input  logic [2:0]        CCtrl,
  output logic              CGnt,
  output logic              CDone,
  output logic [DATA_W-1:0] CRdData,
  output logic              CErr,
  input  logic              LReq,
  input  logic [ADDR_W-1:0] LAddr,
  input  logic [DATA_W-1:0] LWrData,
  input  logic              LWr,
  input  logic [2:0]        LCtrl,
  output logic              LGnt,
  output logic              LDone,
  output logic [DATA_W-1:0] LRdData,
  output logic              LErr,
  output logic [ADDR_W-1:0] DMAddresss,
  output logic [DATA_W-1:0] DMDataWr,
  output logic              DMWr,
  output logic [2:0]        DMCtrl,
  input  logic [DATA_W-1:0] DMDataRd
);

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  req_id_e           r_id;
  logic              r_ptr;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_wr;
  logic [2:0]        r_ctrl;
  logic              r_fwd;
  logic              r_err;

  logic [1:0]        w_pick;
  logic [1:0]        w_gnt;
  logic              w_sel_l;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_wr;
  logic [2:0]        w_ctrl;
  logic              w_valid;
  logic              w_misal;
  logic              w_done;

  dm_rr_picker u_picker (
    .i_req       ({LReq, CReq}),
    .i_prio_mode (PRIO_MODE != 0),
    .i_ptr       (r_ptr),
    .o_gnt       (w_pick)
  );

  assign w_gnt   = (r_state == IDLE && !rst) ? w_pick : 2'b00;
  assign w_sel_l = w_gnt[1];
  assign w_addr  = w_sel_l ? LAddr   : CAddr;
  assign w_wdata = w_sel_l ? LWrData : CWrData;
  assign w_wr    = w_sel_l ? LWr     : CWr;
  assign w_ctrl  = w_sel_l ? LCtrl   : CCtrl;
  assign w_valid = ctrl_valid(w_ctrl, w_wr);

`ifdef DM_ALIGN_CHECK_EN
  assign w_misal = w_valid && ctrl_misaligned(w_ctrl, w_addr[1:0]);
`else
  assign w_misal = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Reset is folded into the strobes so an aborted access never writes or completes.
  always_comb begin
    w_state_nxt = r_state;
    DMWr        = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (|w_gnt) w_state_nxt = ACCESS;
      end
      ACCESS: begin
        w_state_nxt = RESP;
        DMWr        = r_wr && r_fwd && !rst;
      end
      RESP: begin
        w_state_nxt = IDLE;
        w_done      = !rst;
      end
      default: w_state_nxt = IDLE;
    endcase
    CGnt    = w_gnt[0];
    LGnt    = w_gnt[1];
    CDone   = w_done && (r_id == REQ_C);
    LDone   = w_done && (r_id == REQ_L);
    CRdData = CDone ? r_rdata : '0;
    LRdData = LDone ? r_rdata : '0;
    CErr    = CDone && r_err;
    LErr    = LDone && r_err;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_id    <= REQ_C;
      r_ptr   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_wr    <= 1'b0;
      r_ctrl  <= 3'b000;
      r_fwd   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (|w_gnt) begin
        r_id    <= w_sel_l ? REQ_L : REQ_C;
        r_ptr   <= ~w_sel_l;
        r_addr  <= w_addr;
        r_wdata <= w_wdata;
        r_wr    <= w_wr;
        r_ctrl  <= w_ctrl;
        r_fwd   <= w_valid && !w_misal;
        r_err   <= w_misal;
      end
      if (r_state == ACCESS) begin
        r_rdata <= (r_fwd && !r_wr) ? DMDataRd : '0;
      end
    end
  end

  // The latch doubles as the memory-side bus so it only moves on a new grant.
  assign DMAddresss = r_addr;
  assign DMDataWr   = r_wdata;
  assign DMCtrl     = r_ctrl;

endmodule

`default_nettype wire

// File: tb/tb_dm_access_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dm_access_arbiter: scoreboard bench with big-endian byte memory models.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dm_access_arbiter;

  typedef struct packed {
    logic        id;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic mem_clr;
  always #5 clk = ~clk;

  logic        req [2][2];
  logic        wr  [2][2];
  logic [2:0]  ctl [2][2];
  logic [31:0] adr [2][2];
  logic [31:0] wdt [2][2];
  logic        gnt [2][2];
  logic        done[2][2];
  logic        err [2][2];
  logic [31:0] rdt [2][2];
  logic [31:0] dma [2];
  logic [31:0] dmw [2];
  logic [31:0] dmr [2];
  logic        dmwe[2];
  logic [2:0]  dmc [2];

  logic [7:0]  mem [2][64];
  logic [7:0]  b0[2], b1[2], b2[2], b3[2];

  exp_t q0[$];
  exp_t q1[$];
  int n_vec = 0;
  int n_bad = 0;
  int we_cnt[2] = '{0, 0};

  dm_access_arbiter #(.ADDR_W(32), .DATA_W(32), .PRIO_MODE(0)) u_rr (
    .clk(clk), .rst(rst),
    .CReq(req[0][0]), .CAddr(adr[0][0]), .CWrData(wdt[0][0]), .CWr(wr[0][0]), .CCtrl(ctl[0][0]),
    .CGnt(gnt[0][0]), .CDone(done[0][0]), .CRdData(rdt[0][0]), .CErr(err[0][0]),
    .LReq(req[0][1]), .LAddr(adr[0][1]), .LWrData(wdt[0][1]), .LWr(wr[0][1]), .LCtrl(ctl[0][1]),
    .LGnt(gnt[0][1]), .LDone(done[0][1]), .LRdData(rdt[0][1]), .LErr(err[0][1]),
    .DMAddresss(dma[0]), .DMDataWr(dmw[0]), .DMWr(dmwe[0]), .DMCtrl(dmc[0]), .DMDataRd(dmr[0])
  );

  dm_access_arbiter #(.ADDR_W(32), .DATA_W(32), .PRIO_MODE(1)) u_fx (
    .clk(clk), .rst(rst),
    .CReq(req[1][0]), .CAddr(adr[1][0]), .CWrData(wdt[1][0]), .CWr(wr[1][0]), .CCtrl(ctl[1][0]),
    .CGnt(gnt[1][0]), .CDone(done[1][0]), .CRdData(rdt[1][0]), .CErr(err[1][0]),
    .LReq(req[1][1]), .LAddr(adr[1][1]), .LWrData(wdt[1][1]), .LWr(wr[1][1]), .LCtrl(ctl[1][1]),
    .LGnt(gnt[1][1]), .LDone(done[1][1]), .LRdData(rdt[1][1]), .LErr(err[1][1]),
    .DMAddresss(dma[1]), .DMDataWr(dmw[1]), .DMWr(dmwe[1]), .DMCtrl(dmc[1]), .DMDataRd(dmr[1])
  );

  // Big-endian memory: the addressed byte is the most significant one.
  always_comb begin
    for (int m = 0; m < 2; m++) begin
      b0[m]  = mem[m][dma[m][5:0]];
      b1[m]  = mem[m][dma[m][5:0] + 6'd1];
      b2[m]  = mem[m][dma[m][5:0] + 6'd2];
      b3[m]  = mem[m][dma[m][5:0] + 6'd3];
      dmr[m] = 32'h0;
      case (dmc[m])
        3'b000:  dmr[m] = {{24{b0[m][7]}}, b0[m]};
        3'b001:  dmr[m] = {{16{b0[m][7]}}, b0[m], b1[m]};
        3'b010:  dmr[m] = {b0[m], b1[m], b2[m], b3[m]};
        3'b100:  dmr[m] = {24'h0, b0[m]};
        3'b101:  dmr[m] = {16'h0, b0[m], b1[m]};
        default: dmr[m] = 32'h0;
      endcase
    end
  end

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int m = 0; m < 2; m++)
        for (int i = 0; i < 64; i++) mem[m][i] <= 8'h00;
    end else begin
      for (int m = 0; m < 2; m++) begin
        if (dmwe[m]) begin
          case (dmc[m])
            3'b000: mem[m][dma[m][5:0]] <= dmw[m][7:0];
            3'b001: begin
              mem[m][dma[m][5:0]]        <= dmw[m][15:8];
              mem[m][dma[m][5:0] + 6'd1] <= dmw[m][7:0];
            end
            3'b010: begin
              mem[m][dma[m][5:0]]        <= dmw[m][31:24];
              mem[m][dma[m][5:0] + 6'd1] <= dmw[m][23:16];
              mem[m][dma[m][5:0] + 6'd2] <= dmw[m][15:8];
              mem[m][dma[m][5:0] + 6'd3] <= dmw[m][7:0];
            end
            default: ;
          endcase
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic push_exp(input int d, input logic id, input logic [31:0] data, input logic e);
    exp_t x;
    x.id = id; x.data = data; x.err = e;
    if (d == 0) q0.push_back(x);
    else        q1.push_back(x);
  endtask

  // Monitor: every completion pops the next expected response of that DUT.
  always @(negedge clk) begin
    exp_t x;
    for (int d = 0; d < 2; d++) begin
      if (done[d][0] || done[d][1]) begin
        if (done[d][0] && done[d][1]) begin
          chk("both_done", 64'd1, 64'd0);
        end else if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
          chk("spurious_done", {63'd0, done[d][1]}, 64'hFF);
        end else begin
          x = (d == 0) ? q0.pop_front() : q1.pop_front();
          chk("done_id",   {63'd0, done[d][1]}, {63'd0, x.id});
          chk("rd_data",   {32'd0, rdt[d][done[d][1]]}, {32'd0, x.data});
          chk("err_flag",  {63'd0, err[d][done[d][1]]}, {63'd0, x.err});
        end
      end
      if (dmwe[d] && !rst) we_cnt[d] <= we_cnt[d] + 1;
    end
  end

  task automatic wait_gnt(input int d, input int p, output bit got);
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      #1;
      if (gnt[d][p]) got = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic access(input int d, input int p, input logic w, input logic [2:0] c,
                        input logic [31:0] a, input logic [31:0] dat, input logic [31:0] ed,
                        input logic ee, input logic ewe, input bit push);
    bit got;
    @(negedge clk);
    req[d][p] = 1'b1; wr[d][p] = w; ctl[d][p] = c; adr[d][p] = a; wdt[d][p] = dat;
    wait_gnt(d, p, got);
    if (!got) begin
      chk("gnt_timeout", 64'd0, 64'd1);
      req[d][p] = 1'b0;
      return;
    end
    if (push) push_exp(d, p[0], ed, ee);
    @(posedge clk); #1 req[d][p] = 1'b0;
    @(negedge clk); #1;
    chk("dmwr_in_access", {63'd0, dmwe[d]}, {63'd0, ewe});
    chk("dm_addr", {32'd0, dma[d]}, {32'd0, a});
    if (ewe) chk("dm_wdata", {32'd0, dmw[d]}, {32'd0, dat});
    @(negedge clk); #1;
    chk("dmwr_in_resp", {63'd0, dmwe[d]}, 64'd0);
    chk("done_latency", {63'd0, done[d][p]}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    bit got;
    rst = 1'b1; mem_clr = 1'b1;
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) begin
        req[d][p] = 1'b0; wr[d][p] = 1'b0; ctl[d][p] = 3'b000; adr[d][p] = '0; wdt[d][p] = '0;
      end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; mem_clr = 1'b0;

    repeat (5) begin
      @(negedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        chk("rst_strobes", {56'd0, gnt[d][0], gnt[d][1], done[d][0], done[d][1],
                            err[d][0], err[d][1], dmwe[d], 1'b0}, 64'd0);
        chk("rst_rdata", {rdt[d][0], rdt[d][1]}, 64'd0);
        chk("rst_dm", {dma[d], dmw[d]}, 64'd0);
        chk("rst_dmctrl", {61'd0, dmc[d]}, 64'd0);
      end
    end

    // store/load round trip and single L request
    access(0, 0, 1'b1, 3'b010, 32'h8, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1, 1'b1);
    access(0, 0, 1'b0, 3'b010, 32'h8, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1);
    access(0, 1, 1'b0, 3'b010, 32'h8, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1);

    // round-robin: C wins first, then L beats C's immediate re-request
    push_exp(0, 1'b0, 32'hDEADBEEF, 1'b0);
    push_exp(0, 1'b1, 32'hDEADBEEF, 1'b0);
    push_exp(0, 1'b0, 32'h00000000, 1'b0);
    fork
      begin
        access(0, 0, 1'b0, 3'b010, 32'h8, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        access(0, 0, 1'b0, 3'b010, 32'hC, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      end
      access(0, 1, 1'b0, 3'b010, 32'h8, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    join

    // byte/half sizes and sign handling
    access(0, 1, 1'b1, 3'b000, 32'h3, 32'h80, 32'h0, 1'b0, 1'b1, 1'b1);
    access(0, 0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h00000000, 1'b0, 1'b0, 1'b1);
    access(0, 0, 1'b0, 3'b000, 32'h3, 32'h0, 32'hFFFFFF80, 1'b0, 1'b0, 1'b1);
    access(0, 0, 1'b0, 3'b100, 32'h3, 32'h0, 32'h00000080, 1'b0, 1'b0, 1'b1);
    access(0, 0, 1'b0, 3'b010, 32'h0, 32'h0, 32'h00000080, 1'b0, 1'b0, 1'b1);
    access(0, 0, 1'b0, 3'b001, 32'h2, 32'h0, 32'h00000080, 1'b0, 1'b0, 1'b1);
    access(0, 0, 1'b1, 3'b001, 32'hA, 32'h1234, 32'h0, 1'b0, 1'b1, 1'b1);
    access(0, 0, 1'b0, 3'b010, 32'h8, 32'h0, 32'hDEAD1234, 1'b0, 1'b0, 1'b1);

    // invalid codes complete quietly and leave memory untouched
    access(0, 0, 1'b1, 3'b100, 32'h8, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    access(0, 0, 1'b0, 3'b111, 32'h8, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    access(0, 0, 1'b0, 3'b010, 32'h8, 32'h0, 32'hDEAD1234, 1'b0, 1'b0, 1'b1);

`ifdef DM_ALIGN_CHECK_EN
    access(0, 0, 1'b0, 3'b010, 32'h6, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
`else
    access(0, 0, 1'b0, 3'b010, 32'h6, 32'h0, 32'h0000DEAD, 1'b0, 1'b0, 1'b1);
`endif

    // reset during the ACCESS cycle of a store
    @(negedge clk);
    req[0][0] = 1'b1; wr[0][0] = 1'b1; ctl[0][0] = 3'b010; adr[0][0] = 32'h10; wdt[0][0] = 32'h11111111;
    wait_gnt(0, 0, got);
    chk("abort_gnt", {63'd0, got}, 64'd1);
    @(posedge clk); #1 req[0][0] = 1'b0; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); #1;
    chk("abort_no_done", {62'd0, done[0][0], done[0][1]}, 64'd0);
    chk("abort_dmwr", {63'd0, dmwe[0]}, 64'd0);
    @(negedge clk); #1;
    chk("abort_no_done2", {62'd0, done[0][0], done[0][1]}, 64'd0);
    access(0, 0, 1'b0, 3'b010, 32'h8, 32'h0, 32'hDEAD1234, 1'b0, 1'b0, 1'b1);

    // fixed priority: C keeps winning while it re-requests
    access(1, 0, 1'b1, 3'b010, 32'h0, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b1, 1'b1);
    access(1, 1, 1'b1, 3'b010, 32'h4, 32'h5A5A5A5A, 32'h0, 1'b0, 1'b1, 1'b1);
    push_exp(1, 1'b0, 32'hA5A5A5A5, 1'b0);
    push_exp(1, 1'b0, 32'h5A5A5A5A, 1'b0);
    push_exp(1, 1'b1, 32'hA5A5A5A5, 1'b0);
    fork
      begin
        access(1, 0, 1'b0, 3'b010, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        access(1, 0, 1'b0, 3'b010, 32'h4, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      end
      access(1, 1, 1'b0, 3'b010, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    join

    repeat (6) @(negedge clk);
    #1;
    chk("sb_drained", 64'(q0.size() + q1.size()), 64'd0);
    chk("dmwr_pulses_rr", 64'(we_cnt[0]), 64'd3);
    chk("dmwr_pulses_fx", 64'(we_cnt[1]), 64'd2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
